// File: rtl/pin_int_ctrl_pkg.sv
// rtl/pin_int_ctrl_pkg.sv - shared types and constants for the pin interrupt controller
`timescale 1ns/1ps
package pin_int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    INSERV = 2'd2
  } state_t;

  localparam int SRC_A   = 0;
  localparam int SRC_B   = 1;
  localparam int NUM_SRC = 2;

  localparam logic [7:0] VEC_DEFAULT = 8'h00;

endpackage

// File: rtl/pin_int_sync.sv
// rtl/pin_int_sync.sv - pin synchroniser with single-cycle rising-edge pulse
`timescale 1ns/1ps
module pin_int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_n_rst,
  input  logic pin,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge sys_clk or negedge sys_n_rst) begin
    if (!sys_n_rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  // A held level yields exactly one pulse because dly_q catches up one cycle later.
  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/pin_int_ctrl.sv
// rtl/pin_int_ctrl.sv - two-pin interrupt controller with mask, fixed priority and ack/eoi handshake
`timescale 1ns/1ps
module pin_int_ctrl
  import pin_int_ctrl_pkg::*;
#(
  parameter logic [7:0] VEC_A       = 8'h10,
  parameter logic [7:0] VEC_B       = 8'h14,
  parameter logic [1:0] MASK_RST    = 2'b00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_n_rst,
  input  logic       i_pin_inta,
  input  logic       i_pin_intb,
  input  logic       i_mask_we,
  input  logic [1:0] i_mask_wdata,
  input  logic       i_int_ack,
  input  logic       i_int_eoi,
  output logic       o_int_req,
  output logic [7:0] o_int_vec,
  output logic       o_in_service,
  output logic [1:0] o_mask,
  output logic [1:0] o_pending
);

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr;
  state_t             state_q, state_d;
  logic               grant_q, grant_d;
  logic [7:0]         vec_q, vec_d;

  pin_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .sys_clk   (sys_clk),
    .sys_n_rst (sys_n_rst),
    .pin       (i_pin_inta),
    .rise      (rise[SRC_A])
  );

  pin_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .sys_clk   (sys_clk),
    .sys_n_rst (sys_n_rst),
    .pin       (i_pin_intb),
    .rise      (rise[SRC_B])
  );

  assign eligible = pending_q & ~mask_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    vec_d   = vec_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = REQ;
          if (eligible[SRC_A]) begin
            grant_d = 1'(SRC_A);
            vec_d   = VEC_A;
          end else begin
            grant_d = 1'(SRC_B);
            vec_d   = VEC_B;
          end
        end
      end
      // Grant is frozen here: a late higher-priority edge waits for the next IDLE.
      REQ: begin
        if (i_int_ack) begin
          clr[grant_q] = 1'b1;
          state_d      = INSERV;
        end
      end
      INSERV: begin
        if (i_int_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_n_rst) begin
    if (!sys_n_rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      vec_q     <= VEC_DEFAULT;
      pending_q <= '0;
      mask_q    <= MASK_RST;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      vec_q     <= vec_d;
      // A new edge landing on the acknowledge cycle survives the clear.
      pending_q <= (pending_q & ~clr) | rise;
      if (i_mask_we) mask_q <= i_mask_wdata;
    end
  end

  assign o_int_req    = (state_q == REQ);
  assign o_in_service = (state_q == INSERV);
  assign o_int_vec    = vec_q;
  assign o_mask       = mask_q;
  assign o_pending    = pending_q;

endmodule

// File: doc/pin_int_ctrl.md
Name: pin_int_ctrl

Overview:
- Interrupt controller between the external interrupt pins (i_pin_inta, i_pin_intb) and the CPU core's interrupt input inside system_top.
- Synchronises the asynchronous pins to sys_clk and rising-edge-detects them.
- Latches the edges as pending, applies a mask and fixed priority (A over B), then presents one request plus vector to the core.
- The core takes the request with an acknowledge and releases it with an end-of-interrupt. One level of service; no nesting.

Parameters:
- VEC_A, 8'h10: vector presented for source A.
- VEC_B, 8'h14: vector presented for source B.
- MASK_RST, 2'b00: mask register reset value; bit0 = A, bit1 = B; 1 = masked.
- SYNC_STAGES, 2: synchroniser flops per pin, minimum 2.

Ports:
- sys_clk  input  1  system clock; the only clock.
- sys_n_rst  input  1  asynchronous active-low reset.
- i_pin_inta  input  1  asynchronous interrupt pin A; rising edge requests.
- i_pin_intb  input  1  asynchronous interrupt pin B; rising edge requests.
- i_mask_we  input  1  mask write strobe, one cycle.
- i_mask_wdata  input  2  new mask value.
- i_int_ack  input  1  core accepts the current request, one-cycle pulse.
- i_int_eoi  input  1  core finished the service routine, one-cycle pulse.
- o_int_req  output  1  interrupt request to the core.
- o_int_vec  output  8  vector of the granted source; valid while o_int_req or o_in_service is high.
- o_in_service  output  1  a source is being serviced.
- o_mask  output  2  current mask register.
- o_pending  output  2  pending bits {B,A}.

Behaviour:
Reset
- sys_n_rst low clears, immediately and from any state: all synchroniser flops, pending, o_int_req, o_in_service, o_int_vec (to 8'h00) and the internal granted-source index.
- o_mask returns to MASK_RST. State returns to IDLE.
- An edge in flight at reset release is lost.

Pin input
- Each pin passes through SYNC_STAGES flops plus one delay flop.
- rise = last sync stage & ~delay flop.
- Pin pulses must be high for at least 1 sys_clk period plus setup; a 25 ns pulse at 100 MHz is guaranteed caught.
- A level held high produces exactly one rise.

Pending
- pending[i] sets on rise_i. It clears only on i_int_ack for the granted source i.
- If rise_i and the clear for source i fall in the same cycle, set wins and pending stays 1.
- A masked source still latches pending.

Mask
- i_mask_we loads i_mask_wdata on the clock edge; the new mask takes effect next cycle.
- Masking a source while in REQ does not withdraw the request.

Eligibility and priority
- eligible = pending & ~mask. Source A has priority over B.

FSM (IDLE, REQ, INSERV)
- IDLE: if eligible != 0, go to REQ at the next edge. On that edge latch the granted index and o_int_vec (VEC_A or VEC_B) and set o_int_req = 1.
- REQ: o_int_req and o_int_vec are held stable; the grant is not re-arbitrated even if A arrives while B is granted. On i_int_ack: clear pending[granted], o_int_req = 0, o_in_service = 1, go to INSERV.
- INSERV: on i_int_eoi, o_in_service = 0 and go to IDLE. o_int_vec holds its last value.
- Next request after EOI: if anything is eligible in the IDLE cycle, o_int_req rises on the following edge. The minimum gap is 1 cycle low.
- i_int_ack outside REQ and i_int_eoi outside INSERV are ignored.
- i_int_ack and i_int_eoi together are handled per state: only the one valid for the current state acts.

Latency (SYNC_STAGES = 2)
- Let edge k be the first sys_clk edge that samples the pin high.
- Pending sets at edge k+2; o_int_req rises at edge k+3.
- With SYNC_STAGES = N, o_int_req rises at edge k+N+1.

Decomposition:
- Package pin_int_ctrl_pkg holds:
  - the state enum (IDLE, REQ, INSERV);
  - source index constants SRC_A = 0 and SRC_B = 1;
  - the source count of 2;
  - a default vector localparam.
- Sub-module pin_int_sync (parameter SYNC_STAGES): synchroniser plus rising-edge pulse. Instantiate it once per pin.
- Pending, mask, arbitration and the FSM stay in the top module.

Test Plan:
- Reset and single A: sys_n_rst low 13 ns then high; pulse i_pin_inta for 250 ns. Expect o_pending = 2'b01 and o_int_req = 1 with o_int_vec = 8'h10 at edge k+3. Ack then gives o_int_req = 0, o_in_service = 1, o_pending = 2'b00. EOI returns to IDLE.
- Short B pulse: i_pin_intb high for 25 ns at 100 MHz. Expect exactly one request with o_int_vec = 8'h14; a held-high pin gives no second request.
- Priority: A and B rise in the same cycle. Expect vector 8'h10 first. After ack and EOI, o_int_req re-asserts with 8'h14 after exactly 1 low cycle.
- Mask: write 2'b01 then pulse A. Expect o_pending = 2'b01 and o_int_req = 0. Write 2'b00 and expect o_int_req = 1 with vector 8'h10 one cycle after the write edge.
- Simultaneous set/clear: a new A rise lands in the i_int_ack cycle for A. Expect o_pending[0] = 1 after ack, and a new request after EOI. A stray ack in IDLE and a stray EOI in REQ cause no state change.
- Reset mid-service: assert sys_n_rst during INSERV with B pending. Expect all outputs to be zero immediately (o_mask = MASK_RST) and no request after release.
